tick_scheduler: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator for the FFT visualizer datapath. From a single fast clock it produces per-channel one-cycle tick strobes and matching phase square waves (sample strobe, FFT frame start, display refresh) without creating derived clocks. Host logic reprograms each channel's divider through a valid/ready port, and changes are applied glitch-free at period boundaries.

---
 rtl/tick_scheduler_pkg.sv | 14 +
 rtl/tick_channel.sv | 77 +++++++
 rtl/tick_scheduler.sv | 57 +++++
 tb/tb_tick_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and defaults for the tick scheduler and its per-channel counters.
package tick_scheduler_pkg;

  localparam int DEFAULT_DIV_DEF = 4;
  localparam int MAX_CHANNELS    = 16;
  localparam int MAX_WIDTH       = 32;

  // Divider is carried at the widest supported size; each channel keeps its low WIDTH bits.
  typedef struct packed {
    logic                 enable;
    logic [MAX_WIDTH-1:0] divider;
  } ch_cfg_t;

endpackage

// File: rtl/tick_channel.sv
// One clock-enable channel: divide counter, tick strobe and phase square wave, with a
// shadowed divider that is only applied at a terminal count so periods never get cut short.
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic    inClock,
  input  logic    reset,
  input  logic    wr,
  input  ch_cfg_t cfg,
  output logic    tick,
  output logic    phase,
  output logic    active,
  output logic    pending
);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] divider;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] eff_m1;
  logic [WIDTH-1:0] half;
  logic             terminal;
  logic             cfg_unused;

  assign cfg_div    = cfg.divider[WIDTH-1:0];
  assign cfg_unused = ^cfg.divider;

  // A divider of 0 behaves like 1, so the terminal count is 0 in both cases.
  assign eff_m1   = (divider == '0) ? '0 : divider - 1'b1;
  assign half     = eff_m1 >> 1;
  assign terminal = (counter == eff_m1);

  always_ff @(posedge inClock) begin
    if (reset) begin
      counter <= '0;
      divider <= WIDTH'(DEFAULT_DIV);
      shadow  <= WIDTH'(DEFAULT_DIV);
      pending <= 1'b0;
      active  <= 1'b0;
      tick    <= 1'b0;
      phase   <= 1'b0;
    end else if (wr && !cfg.enable) begin
      active  <= 1'b0;
      counter <= '0;
      tick    <= 1'b0;
      phase   <= 1'b0;
      pending <= 1'b0;
    end else if (wr && !active) begin
      divider <= cfg_div;
      active  <= 1'b1;
      counter <= '0;
    end else if (active) begin
      if (terminal) begin
        counter <= '0;
        tick    <= 1'b1;
        phase   <= 1'b1;
        if (pending) begin
          divider <= shadow;
          pending <= 1'b0;
        end
      end else begin
        counter <= counter + 1'b1;
        tick    <= 1'b0;
        if (counter == half) phase <= 1'b0;
      end
      // Writes are only strobed while nothing is pending, so this never fights the clear above.
      if (wr) begin
        shadow  <= cfg_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable generator: decodes host config transfers to per-channel
// write strobes and exposes per-channel back-pressure on cfgReady.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                inClock,
  input  logic                reset,
  input  logic                cfgValid,
  output logic                cfgReady,
  input  logic [CH_BITS-1:0]  cfgChannel,
  input  logic [WIDTH-1:0]    cfgDivider,
  input  logic                cfgEnable,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] phase,
  output logic [CHANNELS-1:0] active
);

  localparam int SLOTS = 1 << CH_BITS;

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] wr;
  logic [SLOTS-1:0]    pending_slot;
  logic                xfer;
  ch_cfg_t             cfg;

  // Unpopulated channel slots read as never pending, so out-of-range writes are accepted.
  assign pending_slot = SLOTS'(pending);
  assign cfgReady     = ~pending_slot[cfgChannel];
  assign xfer         = cfgValid && cfgReady;

  assign cfg.enable  = cfgEnable;
  assign cfg.divider = MAX_WIDTH'(cfgDivider);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i] = xfer && (cfgChannel == CH_BITS'(i));

    tick_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .inClock (inClock),
      .reset   (reset),
      .wr      (wr[i]),
      .cfg     (cfg),
      .tick    (tick[i]),
      .phase   (phase[i]),
      .active  (active[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: a 4-channel instance for the main scenarios and a
// 3-channel instance for the out-of-range channel case.
module tb_tick_scheduler;

  logic        inClock = 1'b0;
  logic        reset = 1'b1;
  logic        cfgValid = 1'b0;
  logic        cfgValid3 = 1'b0;
  logic [1:0]  cfgChannel = 2'd0;
  logic [15:0] cfgDivider = 16'd4;
  logic        cfgEnable = 1'b0;
  logic        cfgReady, cfgReady3;
  logic [3:0]  tick, phase, active;
  logic [2:0]  tick3, phase3, active3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 inClock = ~inClock;

  tick_scheduler #(.CHANNELS(4), .WIDTH(16), .DEFAULT_DIV(4)) dut (
    .inClock(inClock), .reset(reset), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgChannel(cfgChannel), .cfgDivider(cfgDivider), .cfgEnable(cfgEnable),
    .tick(tick), .phase(phase), .active(active)
  );

  tick_scheduler #(.CHANNELS(3), .WIDTH(16), .DEFAULT_DIV(4)) dut3 (
    .inClock(inClock), .reset(reset), .cfgValid(cfgValid3), .cfgReady(cfgReady3),
    .cfgChannel(cfgChannel), .cfgDivider(cfgDivider), .cfgEnable(cfgEnable),
    .tick(tick3), .phase(phase3), .active(active3)
  );

  task automatic step(input int n);
    repeat (n) @(posedge inClock);
    #1;
  endtask

  // Presents one transfer for exactly one edge, then returns 1 ns after that edge.
  task automatic cfg_write(input int ch, input int div, input bit en, input bit to3);
    cfgChannel = 2'(ch);
    cfgDivider = 16'(div);
    cfgEnable  = en;
    if (to3) cfgValid3 = 1'b1;
    else     cfgValid  = 1'b1;
    @(posedge inClock);
    #1;
    cfgValid  = 1'b0;
    cfgValid3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL reset_tick: got %b want 0000", tick); end
    n_cmp++; if (phase !== 4'b0000) begin n_err++; $display("FAIL reset_phase: got %b want 0000", phase); end
    n_cmp++; if (active !== 4'b0000) begin n_err++; $display("FAIL reset_active: got %b want 0000", active); end
    n_cmp++; if (cfgReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cfgReady); end
    n_cmp++; if (active3 !== 3'b000) begin n_err++; $display("FAIL reset_active3: got %b want 000", active3); end
    n_cmp++; if (cfgReady3 !== 1'b1) begin n_err++; $display("FAIL reset_ready3: got %b want 1", cfgReady3); end
  endtask

  task automatic test_ch0_d4();
    logic [11:0] texp = 12'b1000_1000_1000;
    logic [11:0] pexp = 12'b1001_1001_1000;
    cfg_write(0, 4, 1'b1, 1'b0);
    n_cmp++; if (active !== 4'b0001) begin n_err++; $display("FAIL d4_active: got %b want 0001", active); end
    n_cmp++; if (tick[0] !== 1'b0) begin n_err++; $display("FAIL d4_tick_edge0: got %b want 0", tick[0]); end
    for (int k = 1; k <= 12; k++) begin
      step(1);
      n_cmp++;
      if (tick[0] !== texp[k-1]) begin
        n_err++; $display("FAIL d4_tick k=%0d: got %b want %b", k, tick[0], texp[k-1]);
      end
      n_cmp++;
      if (phase[0] !== pexp[k-1]) begin
        n_err++; $display("FAIL d4_phase k=%0d: got %b want %b", k, phase[0], pexp[k-1]);
      end
    end
  endtask

  task automatic test_fast();
    cfg_write(1, 0, 1'b1, 1'b0);
    cfg_write(2, 1, 1'b1, 1'b0);
    step(2);
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (tick[3:1] !== 3'b011) begin n_err++; $display("FAIL fast_tick k=%0d: got %b want 011", k, tick[3:1]); end
      n_cmp++; if (phase[3:1] !== 3'b011) begin n_err++; $display("FAIL fast_phase k=%0d: got %b want 011", k, phase[3:1]); end
      n_cmp++; if (active[3:1] !== 3'b011) begin n_err++; $display("FAIL fast_active k=%0d: got %b want 011", k, active[3:1]); end
      step(1);
    end
  endtask

  task automatic test_pending();
    logic texp, rexp;
    cfg_write(0, 4, 1'b0, 1'b0);
    cfg_write(0, 4, 1'b1, 1'b0);
    step(1);
    cfg_write(0, 6, 1'b1, 1'b0);
    n_cmp++; if (cfgReady !== 1'b0) begin n_err++; $display("FAIL pend_ready k=2: got %b want 0", cfgReady); end
    for (int k = 3; k <= 17; k++) begin
      step(1);
      texp = (k == 4) || (k == 10) || (k == 16);
      rexp = (k >= 4);
      n_cmp++; if (tick[0] !== texp) begin n_err++; $display("FAIL pend_tick k=%0d: got %b want %b", k, tick[0], texp); end
      n_cmp++; if (cfgReady !== rexp) begin n_err++; $display("FAIL pend_ready k=%0d: got %b want %b", k, cfgReady, rexp); end
    end
  endtask

  task automatic test_terminal_write();
    logic texp, rexp;
    cfg_write(0, 4, 1'b0, 1'b0);
    cfg_write(0, 4, 1'b1, 1'b0);
    step(3);
    cfg_write(0, 2, 1'b1, 1'b0);
    n_cmp++; if (tick[0] !== 1'b1) begin n_err++; $display("FAIL term_tick k=4: got %b want 1", tick[0]); end
    n_cmp++; if (cfgReady !== 1'b0) begin n_err++; $display("FAIL term_ready k=4: got %b want 0", cfgReady); end
    // Second request held valid; it must stall until the pending change lands.
    cfgDivider = 16'd8;
    cfgEnable  = 1'b1;
    cfgValid   = 1'b1;
    for (int k = 5; k <= 12; k++) begin
      step(1);
      texp = (k == 8) || (k == 10) || (k == 12);
      rexp = (k >= 8);
      n_cmp++; if (tick[0] !== texp) begin n_err++; $display("FAIL term_tick k=%0d: got %b want %b", k, tick[0], texp); end
      n_cmp++; if (cfgReady !== rexp) begin n_err++; $display("FAIL term_ready k=%0d: got %b want %b", k, cfgReady, rexp); end
      if (k == 8) cfgValid = 1'b0;
    end
  endtask

  task automatic test_disable_reset();
    cfg_write(0, 5, 1'b0, 1'b0);
    cfg_write(0, 5, 1'b1, 1'b0);
    step(6);
    n_cmp++; if (phase[0] !== 1'b1) begin n_err++; $display("FAIL d5_phase k=6: got %b want 1", phase[0]); end
    cfg_write(0, 5, 1'b0, 1'b0);
    n_cmp++; if (tick[0] !== 1'b0) begin n_err++; $display("FAIL dis_tick: got %b want 0", tick[0]); end
    n_cmp++; if (phase[0] !== 1'b0) begin n_err++; $display("FAIL dis_phase: got %b want 0", phase[0]); end
    n_cmp++; if (active[0] !== 1'b0) begin n_err++; $display("FAIL dis_active: got %b want 0", active[0]); end
    cfg_write(0, 5, 1'b1, 1'b0);
    step(1);
    cfg_write(0, 7, 1'b1, 1'b0);
    n_cmp++; if (cfgReady !== 1'b0) begin n_err++; $display("FAIL rst_pre_ready: got %b want 0", cfgReady); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL rst_tick: got %b want 0000", tick); end
    n_cmp++; if (phase !== 4'b0000) begin n_err++; $display("FAIL rst_phase: got %b want 0000", phase); end
    n_cmp++; if (active !== 4'b0000) begin n_err++; $display("FAIL rst_active: got %b want 0000", active); end
    n_cmp++; if (cfgReady !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cfgReady); end
    step(8);
    n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL rst_hold_tick: got %b want 0000", tick); end
    n_cmp++; if (active !== 4'b0000) begin n_err++; $display("FAIL rst_hold_active: got %b want 0000", active); end
  endtask

  task automatic test_out_of_range();
    cfg_write(0, 2, 1'b1, 1'b1);
    step(1);
    n_cmp++; if (active3 !== 3'b001) begin n_err++; $display("FAIL oob_setup_active: got %b want 001", active3); end
    cfgChannel = 2'd3;
    #1;
    n_cmp++; if (cfgReady3 !== 1'b1) begin n_err++; $display("FAIL oob_ready: got %b want 1", cfgReady3); end
    cfg_write(3, 1, 1'b1, 1'b1);
    n_cmp++; if (active3 !== 3'b001) begin n_err++; $display("FAIL oob_en_active: got %b want 001", active3); end
    cfg_write(3, 1, 1'b0, 1'b1);
    n_cmp++; if (active3 !== 3'b001) begin n_err++; $display("FAIL oob_dis_active: got %b want 001", active3); end
    n_cmp++; if (tick3 !== 3'b000) begin n_err++; $display("FAIL oob_tick_odd: got %b want 000", tick3); end
    step(1);
    n_cmp++; if (tick3 !== 3'b001) begin n_err++; $display("FAIL oob_tick_even: got %b want 001", tick3); end
  endtask

  initial begin
    test_reset();
    test_ch0_d4();
    test_fast();
    test_pending();
    test_terminal_write();
    test_disable_reset();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
